// File: rtl/join_pkg.sv
// Shared definitions for the N-channel join.
// Contents:
//   clog2      - constant ceiling log2 used for pointer and sum widths
//   ptr_width  - FIFO pointer width (address bits plus wrap bit) for a depth
//   ptr_t      - pointer type for the default FIFO depth
//   SAT_WRAP / SAT_CLAMP - values of the SAT_MODE parameter
//   cfg_legal  - configuration range check used at elaboration
package join_pkg;

    localparam int SAT_WRAP      = 0;
    localparam int SAT_CLAMP     = 1;
    localparam int DEFAULT_DEPTH = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // One extra bit beyond the address distinguishes full from empty.
    function automatic int ptr_width(input int depth);
        return clog2(depth) + 1;
    endfunction

    typedef logic [ptr_width(DEFAULT_DEPTH)-1:0] ptr_t;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    function automatic bit cfg_legal(input int n_ch, input int depth, input int sat_mode);
        return (n_ch >= 2) && (n_ch <= 8) && is_pow2(depth) && (depth >= 2) &&
               (depth <= 16) && ((sat_mode == SAT_WRAP) || (sat_mode == SAT_CLAMP));
    endfunction

endpackage

// File: rtl/join_chan_fifo.sv
// Single-channel FIFO feeding one input of the join.
// Ports:
//   clk, rst   - clock, synchronous active-high reset (empties the FIFO)
//   push       - write push_data this cycle (ignored when full)
//   push_data  - word to write
//   pop        - drop the head entry this cycle (ignored when empty)
//   head_data  - oldest entry, valid while !empty
//   empty/full - occupancy flags from pointer comparison
// A full FIFO refuses a push even when popped in the same cycle, so full
// depends only on stored occupancy and never on the consumer.
module join_chan_fifo
    import join_pkg::*;
#(
    parameter int D_WIDTH = 6,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [D_WIDTH-1:0] push_data,
    input  logic               pop,
    output logic [D_WIDTH-1:0] head_data,
    output logic               empty,
    output logic               full
);

    localparam int AW = clog2(DEPTH);
    localparam int PW = ptr_width(DEPTH);

    logic [D_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic               push_ok;
    logic               pop_ok;

    // Equal address bits: same wrap bit means empty, different means full.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;
    assign head_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage needs no reset; a write during reset is orphaned by the pointer reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/custom_logic_join_n.sv
// N-channel valid/ready join with per-channel buffering and registered output.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   up_data     - packed channel words, channel i at [i*D_WIDTH +: D_WIDTH]
//   up_valid    - per-channel valid
//   up_ready    - per-channel ready (= channel FIFO not full)
//   down_data   - registered sum (wrapped or clamped per SAT_MODE)
//   down_valid  - registered result valid
//   down_ready  - downstream ready
//   down_sat    - registered; true sum exceeded 2^D_WIDTH-1
//   fire_count  - completed joins since reset, wraps at 2^16
// Handshake: a word moves on any interface at a rising edge where valid and
// ready are both high. up_ready never looks at down_ready or other channels;
// down_valid/down_data/down_sat stay frozen while down_valid & !down_ready.
module custom_logic_join_n
    import join_pkg::*;
#(
    parameter int D_WIDTH  = 6,
    parameter int N_CH     = 2,
    parameter int DEPTH    = 4,
    parameter int SAT_MODE = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_CH*D_WIDTH-1:0]   up_data,
    input  logic [N_CH-1:0]           up_valid,
    output logic [N_CH-1:0]           up_ready,
    output logic [D_WIDTH-1:0]        down_data,
    output logic                      down_valid,
    input  logic                      down_ready,
    output logic                      down_sat,
    output logic [15:0]               fire_count
);

    // Sum width holds N_CH full-scale words without loss.
    localparam int S_W = D_WIDTH + clog2(N_CH);

    if (!cfg_legal(N_CH, DEPTH, SAT_MODE)) begin : g_bad_cfg
        $error("custom_logic_join_n: illegal N_CH/DEPTH/SAT_MODE configuration");
    end

    logic [N_CH-1:0]    empty;
    logic [N_CH-1:0]    full;
    logic [D_WIDTH-1:0] head [N_CH];
    logic               all_avail;
    logic               out_free;
    logic               fire;
    logic [S_W-1:0]     sum;
    logic               over;
    logic [D_WIDTH-1:0] result;

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        join_chan_fifo #(
            .D_WIDTH (D_WIDTH),
            .DEPTH   (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (up_valid[i]),
            .push_data (up_data[i*D_WIDTH +: D_WIDTH]),
            .pop       (fire),
            .head_data (head[i]),
            .empty     (empty[i]),
            .full      (full[i])
        );
    end

    assign up_ready  = ~full;
    assign all_avail = ~|empty;
    assign out_free  = !down_valid || down_ready;
    assign fire      = all_avail && out_free;

    always_comb begin
        sum = '0;
        for (int i = 0; i < N_CH; i++) begin
            sum = sum + S_W'(head[i]);
        end
    end

    // Any bit above the result width means the true sum did not fit.
    assign over   = |sum[S_W-1:D_WIDTH];
    assign result = ((SAT_MODE == SAT_CLAMP) && over) ? {D_WIDTH{1'b1}} : sum[D_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            down_valid <= 1'b0;
            down_data  <= '0;
            down_sat   <= 1'b0;
            fire_count <= '0;
        end else if (fire) begin
            down_valid <= 1'b1;
            down_data  <= result;
            down_sat   <= over;
            fire_count <= fire_count + 16'd1;
        end else if (down_ready) begin
            // Output accepted (or already idle) with nothing new: go idle, keep data.
            down_valid <= 1'b0;
        end
    end

endmodule

// File: doc/custom_logic_join_n.md
Name: custom_logic_join_n

Overview:
N-channel valid/ready join. Each upstream channel is buffered in its own small FIFO. When every channel has at least one entry, one word is popped from each FIFO simultaneously and the words are summed. The sum is presented through a registered output stage, with wrap-around or saturating arithmetic. This is the scalable successor of the two-input combinational join in the scenario designs. Upstream ready no longer depends combinationally on downstream ready or on the other channels' valid.

Parameters:
D_WIDTH, 6, width of each channel word and of the result
N_CH, 2, number of input channels, legal 2..8
DEPTH, 4, entries per channel FIFO, power of two, legal 2..16
SAT_MODE, 0, 0 = sum wraps modulo 2^D_WIDTH; 1 = unsigned saturation at 2^D_WIDTH-1

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
up_data  input  N_CH*D_WIDTH  packed channel words; channel i at [i*D_WIDTH +: D_WIDTH]
up_valid  input  N_CH  per-channel valid
up_ready  output  N_CH  per-channel ready, equal to !full of that channel FIFO
down_data  output  D_WIDTH  registered result
down_valid  output  1  registered result valid
down_ready  input  1  downstream ready
down_sat  output  1  registered; high with down_valid when the true sum exceeded 2^D_WIDTH-1 (meaningful in both modes)
fire_count  output  16  number of completed joins since reset, wraps at 2^16

Behaviour:
- Reset (rst high at a clock edge):
  - all FIFOs empty, so up_ready = all ones the cycle after reset
  - down_valid=0, down_data=0, down_sat=0, fire_count=0
  - pushes in a cycle with rst high are discarded
  - reset mid-transfer drops all buffered words and any pending output
- Channel push: up_valid[i] & up_ready[i] at an edge writes up_data slice i into FIFO i.
  - up_ready[i] depends only on FIFO i occupancy.
  - A full FIFO refuses a push even if it is popped in the same cycle (no pass-through when full).
  - A non-full FIFO accepts a push and a pop in the same cycle; occupancy is unchanged.
- Join condition:
  - all_avail = every FIFO non-empty
  - out_free = !down_valid | down_ready
  - fire = all_avail & out_free
- On fire:
  - pop one entry from every FIFO at the same edge
  - compute full-precision sum S of the N_CH head words, width D_WIDTH+clog2(N_CH)
  - down_data <= SAT_MODE ? min(S, 2^D_WIDTH-1) : S[D_WIDTH-1:0]
  - down_sat <= (S > 2^D_WIDTH-1)
  - down_valid <= 1
  - fire_count++
- No fire and down_ready & down_valid: down_valid <= 0; down_data and down_sat hold their values.
- down_valid & !down_ready: down_data, down_sat and down_valid are held stable (AXI-style; no change while stalled).
- Latency: a word pushed at edge t is at the FIFO head after t. If all other channels are available and the output is free, it is in down_data with down_valid=1 after edge t+1. Minimum latency is 2 cycles.
- Throughput: 1 join/cycle sustained when all channels keep up and down_ready=1.
- Back-pressure:
  - down_ready=0 with down_valid=1 stops pops; FIFOs fill; up_ready drops per channel when full
  - storage capacity = DEPTH words per channel plus 1 output word
- Ordering: the k-th join always combines the k-th word accepted on every channel. Channels never slip relative to each other.
- Unequal arrival: a channel may run up to DEPTH words ahead of the others. The other channels' FIFOs then fill independently.

Decomposition:
- Package join_pkg:
  - localparam function clog2
  - typedef of FIFO pointer width derived from DEPTH
  - constants SAT_WRAP=0 and SAT_CLAMP=1
  - elaboration checks that N_CH is in 2..8 and DEPTH is a power of two
- Sub-module join_chan_fifo (D_WIDTH, DEPTH):
  - one per channel via generate loop
  - ports: clk, rst, push, push_data, pop, head_data, empty, full
  - pointer-plus-extra-bit full/empty detection
- Top level contains the adder tree/loop, saturation, output register and counter.

Test Plan:
- Basic, N_CH=2, D_WIDTH=6, SAT_MODE=0: push 3 on ch0 and 4 on ch1 in the same cycle, down_ready=1 -> down_data=7, down_valid high exactly 2 cycles after the push, down_sat=0, fire_count=1.
- Wrap vs saturate: 40+30 -> SAT_MODE=0 gives down_data=6 with down_sat=1; SAT_MODE=1 gives down_data=63 with down_sat=1.
- Skew, N_CH=3:
  - push 4 words 1,2,3,4 on ch0 only -> up_ready[0]=0 after the 4th push, down_valid stays 0
  - then push 10,20,30,40 on ch1 and ch2 -> outputs 21,42,63,84 mod 64 = 21,42,63,20 in order
- Stall: hold down_ready=0 for 10 cycles with all channels streaming -> down_data stable throughout; each up_ready falls after DEPTH pushes; release -> all DEPTH+1 results delivered in order, no loss or duplication.
- Reset mid-operation: 3 words queued and down_valid=1, assert rst for 1 cycle -> next cycle down_valid=0, fire_count=0, up_ready all ones; no stale word ever emerges.
- Random: N_CH=4, random valid/ready at 50%, 1000 joins -> output stream matches the scoreboard of per-channel queues summed in order; fire_count=1000.
